// File: rtl/spi_target_pkg.sv
// Shared register map, STAT bit positions and SPI state type for the SPI target.
package spi_target_pkg;
    localparam logic [1:0] REG_DATA = 2'd0;
    localparam logic [1:0] REG_STAT = 2'd1;

    localparam int unsigned STAT_RX_VALID    = 0;
    localparam int unsigned STAT_TX_NOT_FULL = 1;
    localparam int unsigned STAT_RX_OVERRUN  = 2;
    localparam int unsigned STAT_TX_UNDERRUN = 3;
    localparam int unsigned STAT_CS_ACTIVE   = 4;

    localparam logic [7:0] IDLE_BYTE = 8'hFF;

    typedef enum logic {
        SPI_IDLE,
        SPI_ACTIVE
    } spi_state_t;
endpackage

// File: rtl/spi_target_fifo.sv
// Synchronous FIFO; a pop in the same cycle frees room for a push when full.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             pop_ok;
    logic             push_ok;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign head    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr[AW-1:0]] <= push_data;
    end
endmodule

// File: rtl/spi_target_sync.sv
// Two-flop synchronizer for a single asynchronous input.
module sync #(
    parameter logic RESET_VALUE = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);
    logic [1:0] stages;

    always_ff @(posedge clk) begin
        if (reset) stages <= {2{RESET_VALUE}};
        else       stages <= {stages[0], d};
    end

    assign q = stages[1];
endmodule

// File: rtl/spi_target.sv
// Memory-mapped SPI target (mode 0, MSB first) with CPU-side RX/TX byte FIFOs.
module spi_target
    import spi_target_pkg::*;
#(
    parameter int unsigned RX_DEPTH = 4,
    parameter int unsigned TX_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        spi_sck_in,
    input  logic        spi_csn_in,
    input  logic        spi_mosi_in,
    output logic        spi_miso_out,
    output logic        spi_miso_en,
    input  logic [31:0] address_in,
    input  logic        sel_in,
    input  logic        read_in,
    output logic [31:0] read_value_out,
    input  logic [3:0]  write_mask_in,
    input  logic [31:0] write_value_in,
    output logic        ready_out
);
    logic sck_s, csn_s, mosi_s, sck_d, csn_d;
    logic sck_rise, sck_fall, csn_fall, csn_rise;
    spi_state_t state, next_state;

    logic [2:0] bit_cnt;
    logic [7:0] rx_shift, tx_shift;
    logic       rx_overrun, tx_underrun;

    logic       rx_push, rx_pop, rx_full, rx_empty;
    logic       tx_push, tx_pop, tx_full, tx_empty;
    logic [7:0] rx_head, tx_head, load_byte;
    logic       spi_rise, spi_fall;
    logic [1:0] reg_sel;
    logic       stat_wr;
    logic [4:0] stat;

    sync #(.RESET_VALUE(1'b0)) u_sck  (.clk(clk), .reset(reset), .d(spi_sck_in),  .q(sck_s));
    sync #(.RESET_VALUE(1'b1)) u_csn  (.clk(clk), .reset(reset), .d(spi_csn_in),  .q(csn_s));
    sync #(.RESET_VALUE(1'b0)) u_mosi (.clk(clk), .reset(reset), .d(spi_mosi_in), .q(mosi_s));

    always_ff @(posedge clk) begin
        if (reset) begin
            sck_d <= 1'b0;
            csn_d <= 1'b1;
        end else begin
            sck_d <= sck_s;
            csn_d <= csn_s;
        end
    end

    assign sck_rise = sck_s && !sck_d;
    assign sck_fall = !sck_s && sck_d;
    assign csn_fall = !csn_s && csn_d;
    assign csn_rise = csn_s && !csn_d;

    always_ff @(posedge clk) begin
        if (reset) state <= SPI_IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            SPI_IDLE:   if (csn_fall) next_state = SPI_ACTIVE;
            SPI_ACTIVE: if (csn_rise) next_state = SPI_IDLE;
            default:    next_state = SPI_IDLE;
        endcase
    end

    // A CSN release wins over any SCK edge seen in the same cycle.
    assign spi_rise  = (state == SPI_ACTIVE) && !csn_rise && sck_rise;
    assign spi_fall  = (state == SPI_ACTIVE) && !csn_rise && sck_fall;
    assign tx_pop    = ((state == SPI_IDLE) && csn_fall) || (spi_fall && (bit_cnt == 3'd0));
    assign load_byte = tx_empty ? IDLE_BYTE : tx_head;
    assign rx_push   = spi_rise && (bit_cnt == 3'd7);

    assign reg_sel = address_in[3:2];
    assign rx_pop  = sel_in && read_in && (reg_sel == REG_DATA);
    assign tx_push = sel_in && write_mask_in[0] && (reg_sel == REG_DATA);
    assign stat_wr = sel_in && write_mask_in[0] && (reg_sel == REG_STAT);

    always_ff @(posedge clk) begin
        if (reset) begin
            bit_cnt     <= '0;
            rx_shift    <= '0;
            tx_shift    <= IDLE_BYTE;
            rx_overrun  <= 1'b0;
            tx_underrun <= 1'b0;
        end else begin
            if ((state == SPI_IDLE) && csn_fall) begin
                bit_cnt  <= '0;
                tx_shift <= load_byte;
            end else if ((state == SPI_ACTIVE) && csn_rise) begin
                bit_cnt <= '0;
            end else if (spi_rise) begin
                rx_shift <= {rx_shift[6:0], mosi_s};
                bit_cnt  <= bit_cnt + 3'd1;
            end else if (spi_fall) begin
                tx_shift <= (bit_cnt == 3'd0) ? load_byte : {tx_shift[6:0], 1'b0};
            end

            if (rx_push && rx_full && !rx_pop)                 rx_overrun <= 1'b1;
            else if (stat_wr && write_value_in[STAT_RX_OVERRUN]) rx_overrun <= 1'b0;

            if (tx_pop && tx_empty)                             tx_underrun <= 1'b1;
            else if (stat_wr && write_value_in[STAT_TX_UNDERRUN]) tx_underrun <= 1'b0;
        end
    end

    sync_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk(clk), .reset(reset),
        .push(rx_push), .push_data({rx_shift[6:0], mosi_s}),
        .pop(rx_pop), .full(rx_full), .empty(rx_empty), .head(rx_head)
    );

    sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk(clk), .reset(reset),
        .push(tx_push), .push_data(write_value_in[7:0]),
        .pop(tx_pop), .full(tx_full), .empty(tx_empty), .head(tx_head)
    );

    assign stat = {state == SPI_ACTIVE, tx_underrun, rx_overrun, !tx_full, !rx_empty};

    always_comb begin
        read_value_out = '0;
        if (sel_in) begin
            case (reg_sel)
                REG_DATA: read_value_out = {24'b0, rx_empty ? 8'h00 : rx_head};
                REG_STAT: read_value_out = {27'b0, stat};
                default:  read_value_out = '0;
            endcase
        end
    end

    assign ready_out    = sel_in;
    assign spi_miso_en  = (state == SPI_ACTIVE);
    assign spi_miso_out = (state == SPI_ACTIVE) ? tx_shift[7] : 1'b1;

    logic unused_bits;
    assign unused_bits = &{1'b0, address_in[31:4], address_in[1:0], write_mask_in[3:1],
                           write_value_in[31:8], write_value_in[1:0], write_value_in[7:4]};
endmodule

// File: tb/tb_spi_target.sv
// Randomized self-checking bench for spi_target against a transaction-level queue model.
module tb_spi_target;
    localparam int unsigned DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        sck = 1'b0, csn = 1'b1, mosi = 1'b0;
    logic        miso, miso_en;
    logic [31:0] address = '0;
    logic        sel = 1'b0, rd = 1'b0;
    logic [31:0] read_value;
    logic [3:0]  write_mask = '0;
    logic [31:0] write_value = '0;
    logic        ready;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [7:0] rx_q[$];
    logic [7:0] tx_q[$];
    logic [7:0] send_q[$];
    logic       m_over = 1'b0, m_under = 1'b0;

    spi_target #(.RX_DEPTH(DEPTH), .TX_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .spi_sck_in(sck), .spi_csn_in(csn), .spi_mosi_in(mosi),
        .spi_miso_out(miso), .spi_miso_en(miso_en),
        .address_in(address), .sel_in(sel), .read_in(rd),
        .read_value_out(read_value), .write_mask_in(write_mask),
        .write_value_in(write_value), .ready_out(ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_write(input logic [3:0] addr, input logic [31:0] v);
        sel = 1'b1; rd = 1'b0; address = {28'b0, addr}; write_mask = 4'h1; write_value = v;
        tick(1);
        sel = 1'b0; write_mask = '0;
    endtask

    task automatic bus_read(input logic [3:0] addr, output logic [31:0] v);
        sel = 1'b1; rd = 1'b1; address = {28'b0, addr}; write_mask = '0;
        #1 v = read_value;
        tick(1);
        sel = 1'b0; rd = 1'b0;
    endtask

    task automatic cpu_write(input logic [7:0] b);
        if (tx_q.size() < DEPTH) tx_q.push_back(b);
        bus_write(4'h0, {24'b0, b});
    endtask

    task automatic cpu_read_data(input string tag);
        logic [31:0] v, exp;
        exp = (rx_q.size() != 0) ? {24'b0, rx_q.pop_front()} : 32'h0;
        bus_read(4'h0, v);
        check(tag, v, exp);
    endtask

    task automatic cpu_check_stat(input string tag, input logic cs);
        logic [31:0] v;
        bus_read(4'h4, v);
        check(tag, v, {27'b0, cs, m_under, m_over, tx_q.size() < DEPTH, rx_q.size() != 0});
    endtask

    task automatic cpu_clear(input logic [31:0] v);
        if (v[2]) m_over = 1'b0;
        if (v[3]) m_under = 1'b0;
        bus_write(4'h4, v);
    endtask

    function automatic logic [7:0] model_load();
        if (tx_q.size() != 0) return tx_q.pop_front();
        m_under = 1'b1;
        return 8'hFF;
    endfunction

    // Sends nbytes from send_q, then a partial byte of 'partial' bits, then releases CSN.
    task automatic host_transfer(input int nbytes, input int partial, input bit stat_mid);
        logic [7:0] cur, txb, got;
        csn = 1'b0;
        cur = model_load();
        tick(4);
        check("miso_en_active", {31'b0, miso_en}, 32'h1);
        for (int b = 0; b < nbytes; b++) begin
            txb = send_q.pop_front();
            got = '0;
            for (int i = 7; i >= 0; i--) begin
                mosi = txb[i];
                tick(4);
                got = {got[6:0], miso};
                sck = 1'b1;
                tick(4);
                sck = 1'b0;
            end
            check("miso_byte", {24'b0, got}, {24'b0, cur});
            if (rx_q.size() < DEPTH) rx_q.push_back(txb);
            else m_over = 1'b1;
            cur = model_load();
        end
        for (int p = 0; p < partial; p++) begin
            mosi = 1'($urandom);
            tick(4);
            sck = 1'b1;
            tick(4);
            sck = 1'b0;
        end
        tick(4);
        if (stat_mid) cpu_check_stat("stat_during_cs", 1'b1);
        csn = 1'b1;
        tick(4);
        check("miso_en_idle", {31'b0, miso_en}, 32'h0);
        check("miso_idle", {31'b0, miso}, 32'h1);
    endtask

    initial begin
        logic [31:0] v;
        tick(3);
        reset = 1'b0;
        tick(1);
        check("reset_miso_en", {31'b0, miso_en}, 32'h0);
        check("reset_miso", {31'b0, miso}, 32'h1);
        cpu_check_stat("reset_stat", 1'b0);
        cpu_read_data("reset_data");

        // Basic exchange
        cpu_write(8'hA5);
        send_q.push_back(8'h3C);
        host_transfer(1, 0, 1'b1);
        cpu_read_data("t1_data");
        cpu_check_stat("t1_stat_after", 1'b0);
        cpu_clear(32'hC);

        // Underrun with empty TX
        send_q.push_back(8'h11);
        host_transfer(1, 0, 1'b0);
        cpu_check_stat("t2_underrun", 1'b0);
        cpu_clear(32'h8);
        cpu_check_stat("t2_cleared", 1'b0);
        cpu_read_data("t2_data");

        // RX overrun
        for (int i = 1; i <= 5; i++) send_q.push_back(8'(i));
        host_transfer(5, 0, 1'b0);
        cpu_check_stat("t3_overrun", 1'b0);
        for (int i = 0; i < 5; i++) cpu_read_data("t3_data");
        cpu_clear(32'hC);

        // Partial byte discarded, next byte clean
        host_transfer(0, 5, 1'b0);
        cpu_check_stat("t4_no_push", 1'b0);
        send_q.push_back(8'h77);
        host_transfer(1, 0, 1'b0);
        cpu_read_data("t4_data");
        cpu_clear(32'hC);

        // Back-to-back burst
        cpu_write(8'h10);
        cpu_write(8'h20);
        send_q.push_back(8'h5A);
        send_q.push_back(8'hC3);
        host_transfer(2, 0, 1'b1);
        cpu_read_data("t5_data0");
        cpu_read_data("t5_data1");
        cpu_clear(32'hC);

        // Reset mid-byte
        cpu_write(8'hE7);
        csn = 1'b0;
        tick(4);
        for (int i = 0; i < 3; i++) begin
            mosi = 1'b1; tick(4); sck = 1'b1; tick(4); sck = 1'b0;
        end
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        csn = 1'b1;
        tx_q.delete(); rx_q.delete(); m_over = 1'b0; m_under = 1'b0;
        check("t6_miso_en", {31'b0, miso_en}, 32'h0);
        check("t6_miso", {31'b0, miso}, 32'h1);
        tick(4);
        cpu_check_stat("t6_stat", 1'b0);
        cpu_read_data("t6_data");

        // Unselected access and unused registers
        sel = 1'b0; rd = 1'b1; address = 32'h0; write_mask = 4'h1; write_value = 32'h99;
        #1;
        check("nosel_value", read_value, 32'h0);
        check("nosel_ready", {31'b0, ready}, 32'h0);
        tick(1);
        rd = 1'b0; write_mask = '0;
        sel = 1'b1; rd = 1'b1; address = 32'h8;
        #1;
        check("reg8_value", read_value, 32'h0);
        check("reg8_ready", {31'b0, ready}, 32'h1);
        tick(1);
        sel = 1'b0; rd = 1'b0;
        bus_write(4'hC, 32'hFFFF_FFFF);
        cpu_check_stat("after_nosel_stat", 1'b0);

        // Randomized traffic
        for (int it = 0; it < 25; it++) begin
            int nw, nb, np, nr;
            nw = $urandom_range(0, 5);
            nb = $urandom_range(0, 5);
            np = (nb == 0) ? $urandom_range(0, 7) : $urandom_range(0, 1) * $urandom_range(1, 7);
            nr = $urandom_range(0, 6);
            for (int i = 0; i < nw; i++) cpu_write(8'($urandom));
            for (int i = 0; i < nb; i++) send_q.push_back(8'($urandom));
            host_transfer(nb, np, 1'($urandom));
            for (int i = 0; i < nr; i++) cpu_read_data("rnd_data");
            cpu_check_stat("rnd_stat", 1'b0);
            if ($urandom_range(0, 1) == 1) cpu_clear({28'b0, 4'($urandom) & 4'hC});
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
